// File: rtl/wavetable_pkg.sv
// Shared definitions for the wavetable bank: wave_type encodings, loader states
// and the pulse-width helper used by the read path.
package wavetable_pkg;

    localparam int WT_MODE_BIT = 2;
    localparam logic WT_PULSE = 1'b0;
    localparam logic WT_RAM = 1'b1;

    localparam logic [1:0] SUB_DIRECT = 2'd0;
    localparam logic [1:0] SUB_INVERT = 2'd1;
    localparam logic [1:0] SUB_LOWER = 2'd2;
    localparam logic [1:0] SUB_UPPER = 2'd3;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } ld_state_t;

    // Number of high entries at the top of the table for each pulse sub-mode.
    function automatic int pulse_width(input logic [1:0] sub, input int depth);
        int w;
        case (sub)
            SUB_DIRECT: w = depth / 2;
            SUB_INVERT: w = depth / 8;
            SUB_LOWER: w = depth / 4;
            default: w = (3 * depth) / 8;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/wavetable_ram.sv
// Banked sample storage: one write port and one registered read port.
// Contents are deliberately not reset so a reset never wipes loaded waveforms.
module wavetable_ram
    import wavetable_pkg::*;
#(
    parameter int SAMPLE_W = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_BANKS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_wr_en,
    input  logic [$clog2(NUM_BANKS)-1:0] i_wr_bank,
    input  logic [DEPTH_LOG2-1:0]        i_wr_addr,
    input  logic [SAMPLE_W-1:0]          i_wr_data,
    input  logic                         i_rd_en,
    input  logic [$clog2(NUM_BANKS)-1:0] i_rd_bank,
    input  logic [DEPTH_LOG2-1:0]        i_rd_addr,
    output logic [SAMPLE_W-1:0]          o_rd_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [SAMPLE_W-1:0] r_mem [NUM_BANKS*DEPTH];
    logic [SAMPLE_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    // A read colliding with a write returns the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wavetable_bank.sv
// Wavetable bank: pulse generator or banked RAM lookup with one-cycle read latency,
// plus a streaming loader that fills one bank at a time.
module wavetable_bank
    import wavetable_pkg::*;
#(
    parameter int SAMPLE_W = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_BANKS = 4,
    parameter int OUT_W = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rd_valid_in,
    input  logic [DEPTH_LOG2-1:0]        rd_addr_in,
    input  logic [$clog2(NUM_BANKS)-1:0] rd_bank_in,
    input  logic [2:0]                   wave_type_in,
    output logic                         rd_valid_out,
    output logic [OUT_W-1:0]             data_out,
    input  logic                         ld_start_in,
    input  logic [$clog2(NUM_BANKS)-1:0] ld_bank_in,
    input  logic                         ld_valid_in,
    input  logic [SAMPLE_W-1:0]          ld_data_in,
    output logic                         ld_busy_out,
    output logic                         ld_done_out
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PAD = OUT_W - SAMPLE_W;
    localparam logic [OUT_W-1:0] TOP_ONES = OUT_W'({SAMPLE_W{1'b1}}) << PAD;

    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Reset asserts immediately but releases two clocks after rst_n_in rises.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [DEPTH_LOG2-1:0] w_xaddr;
    logic                  w_is_ram;
    logic                  w_pulse_hi;
    logic                  w_ram_rd_en;
    logic [SAMPLE_W-1:0]   w_ram_rd_data;

    always_comb begin
        w_xaddr = rd_addr_in;
        case (wave_type_in[1:0])
            SUB_INVERT: w_xaddr = ~rd_addr_in;
            SUB_LOWER: w_xaddr = {1'b0, rd_addr_in[DEPTH_LOG2-1:1]};
            SUB_UPPER: w_xaddr = {1'b1, rd_addr_in[DEPTH_LOG2-1:1]};
            default: w_xaddr = rd_addr_in;
        endcase
    end

    assign w_is_ram = (wave_type_in[WT_MODE_BIT] == WT_RAM);
    assign w_pulse_hi = (int'(rd_addr_in) >= (DEPTH - pulse_width(wave_type_in[1:0], DEPTH)));
    assign w_ram_rd_en = rd_valid_in && w_is_ram;

    logic r_rd_valid;
    logic r_mode;
    logic r_pulse;

    // Mode and pulse level are captured alongside the RAM read so data_out holds between requests.
    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rd_valid <= 1'b0;
            r_mode <= WT_PULSE;
            r_pulse <= 1'b0;
        end else begin
            r_rd_valid <= rd_valid_in;
            if (rd_valid_in) begin
                r_mode <= wave_type_in[WT_MODE_BIT];
                r_pulse <= w_pulse_hi;
            end
        end
    end

    assign rd_valid_out = r_rd_valid;
    assign data_out = (r_mode == WT_PULSE) ? (r_pulse ? TOP_ONES : '0)
                                           : (OUT_W'(w_ram_rd_data) << PAD);

    ld_state_t             r_state;
    ld_state_t             w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [DEPTH_LOG2-1:0] w_ptr_nxt;
    logic [BANK_W-1:0]     r_bank;
    logic [BANK_W-1:0]     w_bank_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_wr_en;

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= LD_IDLE;
            r_ptr <= '0;
            r_bank <= '0;
            r_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr <= w_ptr_nxt;
            r_bank <= w_bank_nxt;
            r_done <= w_done_nxt;
        end
    end

    // A start always restarts the load and drops any sample offered in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt = r_ptr;
        w_bank_nxt = r_bank;
        w_done_nxt = 1'b0;
        w_wr_en = 1'b0;
        if (ld_start_in) begin
            w_state_nxt = LD_LOAD;
            w_ptr_nxt = '0;
            w_bank_nxt = ld_bank_in;
        end else if (r_state == LD_LOAD && ld_valid_in) begin
            w_wr_en = 1'b1;
            if (&r_ptr) begin
                w_state_nxt = LD_IDLE;
                w_ptr_nxt = '0;
                w_done_nxt = 1'b1;
            end else begin
                w_ptr_nxt = r_ptr + 1'b1;
            end
        end
    end

    assign ld_busy_out = (r_state == LD_LOAD);
    assign ld_done_out = r_done;

    wavetable_ram #(
        .SAMPLE_W(SAMPLE_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .NUM_BANKS(NUM_BANKS)
    ) u_ram (
        .i_clk(clk_in),
        .i_wr_en(w_wr_en),
        .i_wr_bank(r_bank),
        .i_wr_addr(r_ptr),
        .i_wr_data(ld_data_in),
        .i_rd_en(w_ram_rd_en),
        .i_rd_bank(rd_bank_in),
        .i_rd_addr(w_xaddr),
        .o_rd_data(w_ram_rd_data)
    );

endmodule

// File: doc/wavetable_bank.md
WAVETABLE_BANK -- requirements
Module: wavetable_bank

Interface
REQ-001 Parameter SAMPLE_W, default 4, stored sample width in bits.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of entries per bank (DEPTH = 2**DEPTH_LOG2).
REQ-003 Parameter NUM_BANKS, default 4, independent wave RAM banks (power of two, >=2).
REQ-004 Parameter OUT_W, default 16, output width, OUT_W >= SAMPLE_W.
REQ-005 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-007 rd_valid_in  input  1  read request strobe.
REQ-008 rd_addr_in  input  DEPTH_LOG2  phase address.
REQ-009 rd_bank_in  input  log2(NUM_BANKS)  bank to read.
REQ-010 wave_type_in  input  3  bit2=1 RAM mode, bit2=0 pulse mode; bits[1:0] sub-mode.
REQ-011 rd_valid_out  output  1  data_out valid for the request.
REQ-012 data_out  output  OUT_W  sample, left-justified, zero-filled LSBs.
REQ-013 ld_start_in  input  1  begin a bank load.
REQ-014 ld_bank_in  input  log2(NUM_BANKS)  bank to load, sampled with ld_start_in.
REQ-015 ld_valid_in  input  1  ld_data_in carries the next sample.
REQ-016 ld_data_in  input  SAMPLE_W  sample to write.
REQ-017 ld_busy_out  output  1  loader is in LOAD.
REQ-018 ld_done_out  output  1  one-cycle pulse when a full bank is written.

Function
REQ-019 Read latency SHALL be exactly one cycle: rd_valid_out(n+1) = rd_valid_in(n); data_out updates only when rd_valid_in was high, otherwise holds.
REQ-020 RAM mode address transform SHALL be: sub 0 addr; sub 1 ~addr; sub 2 {0,addr[MSB:1]}; sub 3 {1,addr[MSB:1]}.
REQ-021 RAM mode data_out SHALL be {mem[bank][xaddr], (OUT_W-SAMPLE_W) zeros}.
REQ-022 Pulse mode SHALL output all-ones in top SAMPLE_W bits when addr >= DEPTH-H, else zero; H = DEPTH/2, DEPTH/8, DEPTH/4, 3*DEPTH/8 for sub 0..3; rd_bank_in ignored.
REQ-023 Loader FSM states IDLE, LOAD; IDLE->LOAD on ld_start_in, capturing ld_bank_in and clearing write pointer to 0.
REQ-024 In LOAD, each cycle with ld_valid_in SHALL write ld_data_in to mem[bank][ptr] and increment ptr.
REQ-025 Write at ptr = DEPTH-1 SHALL return FSM to IDLE, wrap ptr to 0, and pulse ld_done_out next cycle.
REQ-026 ld_start_in during LOAD SHALL restart: new bank captured, ptr=0, no ld_done_out; start wins over a same-cycle ld_valid_in (sample dropped).
REQ-027 ld_valid_in in IDLE SHALL be ignored.
REQ-028 Same-cycle read and write to same bank/entry SHALL return the old (pre-write) value; write visible from the following cycle.
REQ-029 Reads SHALL be permitted during LOAD from any bank, including the one being loaded.

Reset
REQ-030 rst_n_in low SHALL immediately force rd_valid_out=0, data_out=0, ld_busy_out=0, ld_done_out=0, FSM=IDLE, ptr=0, captured bank=0.
REQ-031 RAM contents SHALL NOT be reset; a reset mid-LOAD abandons the load, already-written entries retained.
REQ-032 Deassertion SHALL be synchronised to clk_in inside the block before releasing state.

Structure
REQ-033 Shared package wavetable_pkg SHALL hold wave_type encodings (WT_PULSE, WT_RAM bit, sub-mode codes) and the loader state enum.
REQ-034 Storage SHALL be one sub-module wavetable_ram (NUM_BANKS x DEPTH x SAMPLE_W, one write port, one registered read port).

Verification
REQ-035 Reset then rd_valid_in=1, wave_type=3'b000, addr=8 -> next cycle rd_valid_out=1, data_out=16'hF000; addr=7 -> 16'h0000.
REQ-036 Load bank 2 with samples 0..15, then RAM sub 1 reads addr 0 -> 16'hF000; sub 2 addr 15 -> 16'h7000; ld_done_out one pulse after 16th write.
REQ-037 Pulse sub 1 sweep addr 0..15 -> nonzero only at addr 14,15.
REQ-038 ld_start_in after 5 writes to bank 1 restarting on bank 3 -> bank 1 entries 0..4 kept, bank 3 written from 0, single ld_done_out.
REQ-039 Same-cycle write 4'hA over 4'h3 at bank 0 entry 6 with read of it -> data_out 16'h3000, next read 16'hA000.
REQ-040 Assert rst_n_in mid-LOAD -> outputs zero asynchronously, ld_busy_out=0, later ld_valid_in ignored.
